branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Branch/jump resolution controller for the forwarding, always-taken pipeline.
- Drives the branch comparator's signedness select from the EX-stage funct3 and turns the comparator's less/equal flags into a taken decision.
- Compares the actual next PC with the PC the front end fetched, and on mismatch issues a registered redirect plus a multi-cycle IF/ID and ID/EX flush.
- Sits between the EX-stage datapath (comparator, target adder) and the PC/pipeline-register control.

Parameters:
- N, 32, datapath/PC width.
- FLUSH_CYCLES, 2, cycles o_flush stays high per mispredict; legal range 1..15.
- CNT_W, 32, perf counter width (used only with the optional feature).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_hold  in  1  freezes FSM, flush counter, perf counters and registered outputs.
- i_ex_valid  in  1  EX stage holds a real instruction.
- i_ex_is_branch  in  1  EX instruction is a conditional branch.
- i_ex_is_jump  in  1  EX instruction is JAL/JALR (always taken).
- i_ex_funct3  in  3  branch funct3.
- i_ex_pc  in  N  PC of the EX instruction.
- i_ex_target  in  N  computed branch/jump target.
- i_pred_pc  in  N  PC the front end fetched after this instruction.
- i_br_less  in  1  comparator rs1<rs2.
- i_br_equal  in  1  comparator rs1==rs2.
- o_br_un  out  1  comparator mode: 1 = unsigned, 0 = signed; combinational from i_ex_funct3.
- o_redirect_valid  out  1  one-cycle PC redirect strobe.
- o_redirect_pc  out  N  redirect PC.
- o_flush  out  1  flush IF/ID and ID/EX.
- o_illegal_br  out  1  one-cycle pulse for funct3 010/011 on a branch.
- o_br_count  out  CNT_W  resolved control-transfer count.
- o_mispred_count  out  CNT_W  mispredict count.

Behaviour:
- o_br_un = 1 iff funct3 is 110 or 111; 0 otherwise, including non-branch instructions.
- Taken decision per funct3:
  - 000: equal.
  - 001: !equal.
  - 100 / 110: less.
  - 101 / 111: !less.
  - 010 / 011: not taken, and o_illegal_br pulses the next cycle.
- Jumps are always taken.
- actual_pc = taken ? i_ex_target : i_ex_pc + 4, computed modulo 2^N; wrap from 0xFFFFFFFC gives 0.
- Evaluate happens in IDLE when i_ex_valid && (is_branch || is_jump) && !i_hold. If both is_branch and is_jump are set, is_jump wins.
- Mispredict = evaluate && actual_pc != i_pred_pc.
- FSM states:
  - IDLE: on mispredict, register o_redirect_pc = actual_pc, load flush counter with FLUSH_CYCLES, go to FLUSH.
  - FLUSH: o_flush = 1. o_redirect_valid = 1 only in the first FLUSH cycle. Counter decrements each non-hold cycle; on reaching 1, go to IDLE.
  - In FLUSH, EX inputs are ignored (wrong-path work): no evaluation and no counting.
- Timing: mispredict in EX at cycle T gives redirect at T+1 and o_flush high for cycles T+1..T+FLUSH_CYCLES. A correct prediction produces no outputs.
- A branch in EX on the cycle FLUSH returns to IDLE is evaluated normally, so back-to-back mispredicts flush continuously.
- i_hold: every register holds its value. o_redirect_valid stays asserted while held in the first FLUSH cycle.
- Reset (sync, i_rst_n = 0 at an edge):
  - State goes to IDLE; all outputs except o_br_un clear to 0 and counters clear to 0.
  - o_br_un is combinational and does not reset.
  - Reset during FLUSH aborts the flush; no redirect is re-issued.
- o_redirect_pc holds its last value between redirects.

Optional Feature:
- BRC_PERF_CNT_EN defined:
  - o_br_count increments on every evaluate.
  - o_mispred_count increments on every mispredict.
  - Both counters saturate at 2^CNT_W - 1 and are frozen by i_hold.
- Not defined: both counter outputs are constant 0 and no counter flops are generated.

Test Plan:
- BEQ, funct3 000, eq=1, target 0x100 = pred 0x100, pc 0x40 -> no redirect, no flush; o_br_un=0; br_count=1 with macro.
- BNE, eq=1, pc 0x40, pred 0x80 -> redirect_valid=1 next cycle, redirect_pc=0x44, o_flush high 2 cycles (FLUSH_CYCLES=2), mispred_count=1.
- BLTU funct3 110 -> o_br_un=1 same cycle. less=0, pc 0xFFFFFFFC, pred 0x0 -> no mispredict (PC wraps to 0).
- JALR target 0x200, pred 0x1F0 -> redirect 0x200. A second mispredicting branch presented during FLUSH is ignored. A mispredicting branch on the final flush cycle is accepted and flush stays continuous.
- funct3 011 branch, pred = pc+4 -> o_illegal_br pulse, no redirect.
- Reset asserted on the second FLUSH cycle -> next cycle o_flush=0, o_redirect_valid=0, state IDLE, counters 0. i_hold during the first FLUSH cycle keeps redirect_valid=1 until hold drops.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: EX-stage branch/jump resolution for the always-taken,
// forwarding pipeline. Selects comparator signedness, decides taken, compares
// the resolved next PC against the fetched PC and, on mismatch, issues a
// one-cycle registered redirect plus a FLUSH_CYCLES-long IF/ID + ID/EX flush.
// Optional feature macro: BRC_PERF_CNT_EN (saturating resolve/mispredict
// counters). Without it both counter outputs are tied to zero.
module branch_resolve_ctrl #(
    parameter int N            = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_hold,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_branch,
    input  logic             i_ex_is_jump,
    input  logic [2:0]       i_ex_funct3,
    input  logic [N-1:0]     i_ex_pc,
    input  logic [N-1:0]     i_ex_target,
    input  logic [N-1:0]     i_pred_pc,
    input  logic             i_br_less,
    input  logic             i_br_equal,
    output logic             o_br_un,
    output logic             o_redirect_valid,
    output logic [N-1:0]     o_redirect_pc,
    output logic             o_flush,
    output logic             o_illegal_br,
    output logic [CNT_W-1:0] o_br_count,
    output logic [CNT_W-1:0] o_mispred_count
);

    localparam int FCW = 4;
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_FLUSH
    } state_t;

    state_t         state_q, state_d;
    logic [FCW-1:0] cnt_q, cnt_d;

    logic           cond_taken;
    logic           illegal_f3;
    logic           taken;
    logic [N-1:0]   actual_pc;
    logic           can_eval;
    logic           evaluate;
    logic           mispredict;
    logic           illegal_ev;

    logic           redirect_valid_q;
    logic [N-1:0]   redirect_pc_q;
    logic           illegal_q;

    // Unsigned compare only for BLTU/BGEU; non-branches leave the comparator signed.
    assign o_br_un = i_ex_is_branch && (i_ex_funct3[2:1] == 2'b11);

    // Conditional-branch outcome from comparator flags, plus reserved funct3 detect.
    always_comb begin
        cond_taken = 1'b0;
        illegal_f3 = 1'b0;
        case (i_ex_funct3)
            3'b000: cond_taken = i_br_equal;
            3'b001: cond_taken = !i_br_equal;
            3'b100: cond_taken = i_br_less;
            3'b110: cond_taken = i_br_less;
            3'b101: cond_taken = !i_br_less;
            3'b111: cond_taken = !i_br_less;
            3'b010: illegal_f3 = 1'b1;
            3'b011: illegal_f3 = 1'b1;
        endcase
    end

    // Jump overrides the branch decode when both flags are set.
    assign taken     = i_ex_is_jump || cond_taken;
    assign actual_pc = taken ? i_ex_target : (i_ex_pc + N'(4));

    // The last FLUSH cycle also accepts a new resolution so back-to-back
    // mispredicts keep the flush continuous with no idle gap.
    assign can_eval   = (state_q == S_IDLE) || (cnt_q == FCW'(1));
    assign evaluate   = can_eval && i_ex_valid && (i_ex_is_branch || i_ex_is_jump) && !i_hold;
    assign mispredict = evaluate && (actual_pc != i_pred_pc);
    assign illegal_ev = evaluate && !i_ex_is_jump && illegal_f3;

    // Next-state and flush counter: (re)load on mispredict, count down otherwise.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (mispredict) begin
                    state_d = S_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            S_FLUSH: begin
                if (mispredict) begin
                    state_d = S_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else if (cnt_q == FCW'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - FCW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; i_hold freezes everything.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            illegal_q        <= 1'b0;
        end else if (!i_hold) begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_valid_q <= mispredict;
            illegal_q        <= illegal_ev;
            if (mispredict) begin
                redirect_pc_q <= actual_pc;
            end
        end
    end

    assign o_flush          = (state_q == S_FLUSH);
    assign o_redirect_valid = redirect_valid_q;
    assign o_redirect_pc    = redirect_pc_q;
    assign o_illegal_br     = illegal_q;

`ifdef BRC_PERF_CNT_EN
    logic [CNT_W-1:0] br_count_q;
    logic [CNT_W-1:0] mispred_count_q;

    // Saturating performance counters; evaluate already excludes held cycles.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else if (!i_hold) begin
            if (evaluate && (br_count_q != '1)) begin
                br_count_q <= br_count_q + CNT_W'(1);
            end
            if (mispredict && (mispred_count_q != '1)) begin
                mispred_count_q <= mispred_count_q + CNT_W'(1);
            end
        end
    end

    assign o_br_count      = br_count_q;
    assign o_mispred_count = mispred_count_q;
`else
    assign o_br_count      = '0;
    assign o_mispred_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed, table-driven bench for branch_resolve_ctrl
// with hand-written sequences for flush overlap, hold and reset-in-flush.
module tb_branch_resolve_ctrl;

    localparam int N  = 32;
    localparam int FC = 2;
    localparam int CW = 32;

    logic          clk;
    logic          rst_n;
    logic          hold;
    logic          ex_valid;
    logic          ex_is_branch;
    logic          ex_is_jump;
    logic [2:0]    ex_funct3;
    logic [N-1:0]  ex_pc;
    logic [N-1:0]  ex_target;
    logic [N-1:0]  pred_pc;
    logic          br_less;
    logic          br_equal;
    logic          br_un;
    logic          redirect_valid;
    logic [N-1:0]  redirect_pc;
    logic          flush;
    logic          illegal_br;
    logic [CW-1:0] br_count;
    logic [CW-1:0] mispred_count;

    branch_resolve_ctrl #(
        .N            (N),
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_hold           (hold),
        .i_ex_valid       (ex_valid),
        .i_ex_is_branch   (ex_is_branch),
        .i_ex_is_jump     (ex_is_jump),
        .i_ex_funct3      (ex_funct3),
        .i_ex_pc          (ex_pc),
        .i_ex_target      (ex_target),
        .i_pred_pc        (pred_pc),
        .i_br_less        (br_less),
        .i_br_equal       (br_equal),
        .o_br_un          (br_un),
        .o_redirect_valid (redirect_valid),
        .o_redirect_pc    (redirect_pc),
        .o_flush          (flush),
        .o_illegal_br     (illegal_br),
        .o_br_count       (br_count),
        .o_mispred_count  (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        br;
        logic        jmp;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [31:0] pred;
        logic        less;
        logic        eq;
        logic        x_un;
        logic        x_redir;
        logic [31:0] x_pc;
        logic        x_ill;
    } vec_t;

    vec_t vecs[13];

    int passed = 0;
    int total  = 0;
    int exp_br = 0;
    int exp_mis = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic b, input logic j, input logic [2:0] f,
                         input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] pred,
                         input logic lt, input logic eq);
        ex_valid     = v;
        ex_is_branch = b;
        ex_is_jump   = j;
        ex_funct3    = f;
        ex_pc        = pc;
        ex_target    = tgt;
        pred_pc      = pred;
        br_less      = lt;
        br_equal     = eq;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic chk_counters(input string tag);
`ifdef BRC_PERF_CNT_EN
        chk({tag, "_br_count"}, 64'(br_count), 64'(exp_br));
        chk({tag, "_mispred_count"}, 64'(mispred_count), 64'(exp_mis));
`else
        chk({tag, "_br_count"}, 64'(br_count), 64'h0);
        chk({tag, "_mispred_count"}, 64'(mispred_count), 64'h0);
`endif
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("v%0d", idx);
        drive(v.valid, v.br, v.jmp, v.f3, v.pc, v.tgt, v.pred, v.less, v.eq);
        #1;
        chk({t, "_br_un"}, 64'(br_un), 64'(v.x_un));
        if (v.valid && (v.br || v.jmp)) exp_br++;
        if (v.x_redir) exp_mis++;
        step();
        idle();
        chk({t, "_redir_valid"}, 64'(redirect_valid), 64'(v.x_redir));
        chk({t, "_flush"}, 64'(flush), 64'(v.x_redir));
        chk({t, "_illegal"}, 64'(illegal_br), 64'(v.x_ill));
        if (v.x_redir) begin
            chk({t, "_redir_pc"}, 64'(redirect_pc), 64'(v.x_pc));
            for (int k = 2; k <= FC; k++) begin
                step();
                chk({t, "_flush_mid"}, 64'(flush), 64'h1);
                chk({t, "_redir_valid_mid"}, 64'(redirect_valid), 64'h0);
            end
            step();
            chk({t, "_flush_end"}, 64'(flush), 64'h0);
            chk({t, "_redir_pc_held"}, 64'(redirect_pc), 64'(v.x_pc));
        end else begin
            step();
            chk({t, "_illegal_gone"}, 64'(illegal_br), 64'h0);
            chk({t, "_flush_idle"}, 64'(flush), 64'h0);
        end
    endtask

    initial begin
        //            valid br  jmp f3      pc            tgt           pred          lt  eq  un  rd  rd_pc         ill
        vecs[0]  = '{1'b1,1'b1,1'b0,3'b000,32'h0000_0040,32'h0000_0100,32'h0000_0100,1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b0,3'b001,32'h0000_0040,32'h0000_0080,32'h0000_0080,1'b0,1'b1,1'b0,1'b1,32'h0000_0044,1'b0};
        vecs[2]  = '{1'b1,1'b1,1'b0,3'b110,32'hFFFF_FFFC,32'h0000_1000,32'h0000_0000,1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0};
        vecs[3]  = '{1'b1,1'b1,1'b0,3'b100,32'h0000_0100,32'h0000_0300,32'h0000_0104,1'b1,1'b0,1'b0,1'b1,32'h0000_0300,1'b0};
        vecs[4]  = '{1'b1,1'b1,1'b0,3'b101,32'h0000_0200,32'h0000_0400,32'h0000_0204,1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0};
        vecs[5]  = '{1'b1,1'b1,1'b0,3'b111,32'h0000_0500,32'h0000_0600,32'h0000_0600,1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0};
        vecs[6]  = '{1'b1,1'b1,1'b0,3'b011,32'h0000_0700,32'h0000_0900,32'h0000_0704,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1};
        vecs[7]  = '{1'b1,1'b1,1'b0,3'b010,32'h0000_0800,32'h0000_0A00,32'h0000_0900,1'b1,1'b1,1'b0,1'b1,32'h0000_0804,1'b1};
        vecs[8]  = '{1'b1,1'b0,1'b1,3'b000,32'h0000_1000,32'h0000_2000,32'h0000_1004,1'b0,1'b0,1'b0,1'b1,32'h0000_2000,1'b0};
        vecs[9]  = '{1'b1,1'b1,1'b1,3'b000,32'h0000_1000,32'h0000_3000,32'h0000_3000,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0};
        vecs[10] = '{1'b0,1'b1,1'b0,3'b001,32'h0000_0040,32'h0000_0080,32'h0000_0080,1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0};
        vecs[11] = '{1'b1,1'b0,1'b0,3'b110,32'h0000_0040,32'h0000_0080,32'h0000_0080,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0};
        vecs[12] = '{1'b1,1'b1,1'b0,3'b000,32'h0000_0040,32'h0000_0100,32'h0000_0100,1'b0,1'b0,1'b0,1'b1,32'h0000_0044,1'b0};

        rst_n = 1'b0;
        hold  = 1'b0;
        idle();
        step();
        step();
        chk("rst_redir_valid", 64'(redirect_valid), 64'h0);
        chk("rst_redir_pc", 64'(redirect_pc), 64'h0);
        chk("rst_flush", 64'(flush), 64'h0);
        chk("rst_illegal", 64'(illegal_br), 64'h0);
        chk_counters("rst");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 13; i++) begin
            apply_vec(i, vecs[i]);
        end
        chk_counters("table");

        // JALR mispredict; wrong-path branch in first FLUSH cycle ignored;
        // mispredicting branch on the final FLUSH cycle accepted.
        drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0010, 32'h0000_0200, 32'h0000_01F0, 1'b0, 1'b0);
        exp_br++; exp_mis++;
        step();
        chk("jalr_redir_valid", 64'(redirect_valid), 64'h1);
        chk("jalr_redir_pc", 64'(redirect_pc), 64'h200);
        chk("jalr_flush1", 64'(flush), 64'h1);
        drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0050, 32'h0000_0100, 32'h0000_0999, 1'b0, 1'b0);
        step();
        chk("wrongpath_redir_valid", 64'(redirect_valid), 64'h0);
        chk("wrongpath_redir_pc", 64'(redirect_pc), 64'h200);
        chk("wrongpath_flush2", 64'(flush), 64'h1);
        drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_0060, 32'h0000_0100, 32'h0000_0000, 1'b0, 1'b1);
        exp_br++; exp_mis++;
        step();
        idle();
        chk("b2b_redir_valid", 64'(redirect_valid), 64'h1);
        chk("b2b_redir_pc", 64'(redirect_pc), 64'h64);
        chk("b2b_flush_cont", 64'(flush), 64'h1);
        step();
        chk("b2b_flush2", 64'(flush), 64'h1);
        chk("b2b_redir_valid2", 64'(redirect_valid), 64'h0);
        step();
        chk("b2b_flush_end", 64'(flush), 64'h0);
        chk_counters("b2b");

        // Hold in IDLE blocks evaluation; hold in first FLUSH cycle keeps the strobe.
        drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0040, 32'h0000_0100, 32'h0000_0100, 1'b0, 1'b0);
        hold = 1'b1;
        step();
        chk("hold_idle_redir", 64'(redirect_valid), 64'h0);
        chk("hold_idle_flush", 64'(flush), 64'h0);
        hold = 1'b0;
        exp_br++; exp_mis++;
        step();
        idle();
        chk("hold_redir_valid", 64'(redirect_valid), 64'h1);
        chk("hold_redir_pc", 64'(redirect_pc), 64'h44);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("held_redir_valid", 64'(redirect_valid), 64'h1);
            chk("held_flush", 64'(flush), 64'h1);
        end
        hold = 1'b0;
        step();
        chk("unheld_redir_valid", 64'(redirect_valid), 64'h0);
        chk("unheld_flush", 64'(flush), 64'h1);
        step();
        chk("unheld_flush_end", 64'(flush), 64'h0);
        chk_counters("hold");

        // Reset on the second FLUSH cycle aborts the flush.
        drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_0040, 32'h0000_0080, 32'h0000_0080, 1'b0, 1'b1);
        step();
        idle();
        chk("rf_redir_valid", 64'(redirect_valid), 64'h1);
        step();
        chk("rf_flush2", 64'(flush), 64'h1);
        rst_n = 1'b0;
        step();
        exp_br = 0; exp_mis = 0;
        chk("rf_flush_abort", 64'(flush), 64'h0);
        chk("rf_redir_valid_clr", 64'(redirect_valid), 64'h0);
        chk("rf_redir_pc_clr", 64'(redirect_pc), 64'h0);
        chk("rf_illegal_clr", 64'(illegal_br), 64'h0);
        chk_counters("rf");
        rst_n = 1'b1;
        step();
        chk("rf_after_flush", 64'(flush), 64'h0);
        chk("rf_after_redir", 64'(redirect_valid), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
